// File: rtl/quad_encoder_mc.sv
// Multi-channel quadrature encoder interface: filtered A/B/Z inputs, x4 decoding, step/position/period tracking, snapshots.
// Optional QUAD_ENCODER_MC_INDEX_CHECK_EN adds idx_err, a sticky per-channel index-consistency flag.
module quad_encoder_mc #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PER_W    = 24,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         A,
  input  logic [NUM_CH-1:0]         B,
  input  logic [NUM_CH-1:0]         Z,
  input  logic                      trigger,
  input  logic                      err_clr,
  input  logic [NUM_CH*CNT_W-1:0]   pulses_per_rev,
  output logic [NUM_CH*CNT_W-1:0]   steps_synced,
  output logic [NUM_CH*CNT_W-1:0]   position_synced,
  output logic [NUM_CH*PER_W-1:0]   period_synced,
  output logic [NUM_CH-1:0]         dir_synced,
  output logic [NUM_CH-1:0]         err_sticky,
  output logic [NUM_CH*16-1:0]      err_count,
`ifdef QUAD_ENCODER_MC_INDEX_CHECK_EN
  output logic [NUM_CH-1:0]         idx_err,
`endif
  output logic                      done
);

  localparam int unsigned NIN  = 3 * NUM_CH;
  localparam int unsigned FW   = $clog2(FILT_LEN + 1);
  localparam int unsigned ZOFF = 2 * NUM_CH;

  typedef enum logic [1:0] {AB_00 = 2'b00, AB_01 = 2'b01, AB_10 = 2'b10, AB_11 = 2'b11} ab_t;

  logic [NIN-1:0]   s1, s2, filt;
  logic [FW-1:0]    fcnt [NIN];

  ab_t              state     [NUM_CH];
  ab_t              state_nxt [NUM_CH];
  ab_t              ab        [NUM_CH];
  logic [NUM_CH-1:0] inc_step, dec_step, illegal;

  logic [CNT_W-1:0] steps   [NUM_CH];
  logic [CNT_W-1:0] pos     [NUM_CH];
  logic [CNT_W-1:0] pos_max [NUM_CH];
  logic [PER_W-1:0] per_cnt [NUM_CH];
  logic [PER_W-1:0] period  [NUM_CH];
  logic [15:0]      errc    [NUM_CH];
  logic [NUM_CH-1:0] know_pos, dir, z_prev, z_rise;
  logic             trig_d;

  // Two-flop synchroniser plus persistence filter on every raw pin ({Z, B, A}).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      filt <= '0;
      for (int unsigned i = 0; i < NIN; i++) fcnt[i] <= '0;
    end else begin
      s1 <= {Z, B, A};
      s2 <= s1;
      for (int unsigned i = 0; i < NIN; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // Gray decoder state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) state[i] <= AB_00;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) state[i] <= state_nxt[i];
    end
  end

  // Next state and step classification: forward is 00->10->11->01->00.
  always_comb begin
    inc_step = '0;
    dec_step = '0;
    illegal  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ab[i]        = ab_t'({filt[i], filt[NUM_CH+i]});
      state_nxt[i] = ab[i];
      case (state[i])
        AB_00:   begin inc_step[i] = (ab[i] == AB_10); dec_step[i] = (ab[i] == AB_01); end
        AB_10:   begin inc_step[i] = (ab[i] == AB_11); dec_step[i] = (ab[i] == AB_00); end
        AB_11:   begin inc_step[i] = (ab[i] == AB_01); dec_step[i] = (ab[i] == AB_10); end
        default: begin inc_step[i] = (ab[i] == AB_00); dec_step[i] = (ab[i] == AB_11); end
      endcase
      illegal[i] = ((2'(state[i]) ^ 2'(ab[i])) == 2'b11);
      z_rise[i]  = filt[ZOFF+i] & ~z_prev[i];
      pos_max[i] = pulses_per_rev[i*CNT_W +: CNT_W] - CNT_W'(1);
    end
  end

  // Per-channel counters, position, period and error tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        steps[i]   <= '0;
        pos[i]     <= '1;
        per_cnt[i] <= '0;
        period[i]  <= '1;
        errc[i]    <= '0;
      end
      know_pos   <= '0;
      dir        <= '0;
      z_prev     <= '0;
      err_sticky <= '0;
`ifdef QUAD_ENCODER_MC_INDEX_CHECK_EN
      idx_err    <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        z_prev[i] <= filt[ZOFF+i];

        if (inc_step[i])      steps[i] <= steps[i] + CNT_W'(1);
        else if (dec_step[i]) steps[i] <= steps[i] - CNT_W'(1);

        if (z_rise[i]) begin
          pos[i]      <= '0;
          know_pos[i] <= 1'b1;
        end else if (know_pos[i] && inc_step[i]) begin
          pos[i] <= (pos[i] == pos_max[i]) ? '0 : pos[i] + CNT_W'(1);
        end else if (know_pos[i] && dec_step[i]) begin
          pos[i] <= (pos[i] == '0) ? pos_max[i] : pos[i] - CNT_W'(1);
        end

        // Period capture; a stalled channel reports all-ones as soon as per_cnt saturates.
        if (inc_step[i] || dec_step[i]) begin
          period[i]  <= (&per_cnt[i]) ? '1 : per_cnt[i] + PER_W'(1);
          per_cnt[i] <= '0;
          dir[i]     <= inc_step[i];
        end else begin
          if (!(&per_cnt[i])) per_cnt[i] <= per_cnt[i] + PER_W'(1);
          if (&per_cnt[i][PER_W-1:1]) period[i] <= '1;
        end

        if (illegal[i]) begin
          err_sticky[i] <= 1'b1;
          errc[i]       <= err_clr ? 16'd1 : ((&errc[i]) ? errc[i] : errc[i] + 16'd1);
        end else if (err_clr) begin
          err_sticky[i] <= 1'b0;
          errc[i]       <= '0;
        end

`ifdef QUAD_ENCODER_MC_INDEX_CHECK_EN
        if (z_rise[i] && know_pos[i] && (pos[i] != '0) && (pos[i] != pos_max[i]))
          idx_err[i] <= 1'b1;
        else if (err_clr)
          idx_err[i] <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    err_count = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) err_count[i*16 +: 16] = errc[i];
  end

  // Snapshot of all channels; done rises the edge after the last trigger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      steps_synced    <= '0;
      position_synced <= '1;
      period_synced   <= '1;
      dir_synced      <= '0;
      done            <= 1'b0;
      trig_d          <= 1'b0;
    end else begin
      trig_d <= trigger;
      if (trigger) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          steps_synced[i*CNT_W +: CNT_W]    <= steps[i];
          position_synced[i*CNT_W +: CNT_W] <= know_pos[i] ? pos[i] : '1;
          period_synced[i*PER_W +: PER_W]   <= period[i];
        end
        dir_synced <= dir;
        done       <= 1'b0;
      end else if (trig_d) begin
        done <= 1'b1;
      end
    end
  end

endmodule
